// File: rtl/wb_port_arbiter_if.sv
// Write-port bus between the writeback mux / long-latency unit and the regfile arbiter.
// The slave side is the arbiter; the master side drives pipeline and LU results.
interface wb_port_arbiter_if #(
  parameter int W     = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          RegWriteW;
  logic [AW-1:0] RdW;
  logic [W-1:0]  ResultW;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_rd;
  logic [W-1:0]  lu_data;
  logic          stall_req;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [W-1:0]  rf_wd;
  logic [CW-1:0] pend_cnt;

  modport slave (
    input  RegWriteW, RdW, ResultW, lu_valid, lu_rd, lu_data,
    output lu_ready, stall_req, rf_we, rf_addr, rf_wd, pend_cnt
  );

  modport master (
    output RegWriteW, RdW, ResultW, lu_valid, lu_rd, lu_data,
    input  lu_ready, stall_req, rf_we, rf_addr, rf_wd, pend_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writes win, LU results queue and drain in idle
// slots, and a starvation timer requests a writeback bubble when the queue head waits too long.
module wb_port_arbiter #(
  parameter int W        = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_port_arbiter_if.slave   bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  state_t         state;
  logic [AW-1:0]  q_rd   [DEPTH];
  logic [W-1:0]   q_data [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic [WCW-1:0] wait_cnt;
  logic           stall_q;
  logic           full, empty, pipe_wr, pop, push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Gating with rst_n keeps the write port quiet for the whole reset window.
  assign pipe_wr = rst_n && bus.RegWriteW && (bus.RdW != '0);
  assign pop     = !pipe_wr && !empty;
  // x0 results complete the handshake but are dropped on the floor.
  assign push    = bus.lu_valid && !full && (bus.lu_rd != '0);
  assign count_nxt = count + CW'(push) - CW'(pop);

  assign bus.lu_ready  = !full;
  assign bus.pend_cnt  = count;
  assign bus.stall_req = stall_q;

  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_addr = '0;
    bus.rf_wd   = '0;
    if (pipe_wr) begin
      bus.rf_we   = 1'b1;
      bus.rf_addr = bus.RdW;
      bus.rf_wd   = bus.ResultW;
    end else if (!empty) begin
      bus.rf_we   = 1'b1;
      bus.rf_addr = q_rd[rd_ptr];
      bus.rf_wd   = q_data[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= bus.lu_rd;
      q_data[wr_ptr] <= bus.lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      if (pop || empty)
        wait_cnt <= '0;
      else if (wait_cnt != WCW'(MAX_WAIT))
        wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      stall_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (push) state <= WAIT;
        WAIT: begin
          if (pop && count_nxt == '0) begin
            state <= IDLE;
          end else if (!pop && wait_cnt >= WCW'(MAX_WAIT - 1)) begin
            state   <= FORCE;
            stall_q <= 1'b1;
          end
        end
        // Stay here while the pipeline keeps winning; only a pop releases the bubble.
        FORCE: begin
          if (pop) begin
            stall_q <= 1'b0;
            state   <= (count_nxt == '0) ? IDLE : WAIT;
          end
        end
        default: begin
          state   <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_wb_port_arbiter;
  localparam int W = 32, AW = 5, DEPTH = 4, MAX_WAIT = 8;

  typedef struct { logic [AW-1:0] rd; logic [W-1:0] data; } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0, n_fail = 0;
  bit   cmp_en = 0;
  ent_t mq[$];
  int   waited;

  wb_port_arbiter_if #(.W(W), .AW(AW), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.W(W), .AW(AW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending results and a count of cycles the head has waited.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      waited <= 0;
    end else begin
      bit was_full, pop;
      was_full = (mq.size() >= DEPTH);
      pop = !(bus.RegWriteW && bus.RdW != 0) && (mq.size() > 0);
      if (pop) begin
        void'(mq.pop_front());
        waited <= 0;
      end else if (mq.size() > 0) waited <= waited + 1;
      else waited <= 0;
      if (bus.lu_valid && !was_full && bus.lu_rd != 0) mq.push_back('{bus.lu_rd, bus.lu_data});
    end
  end

  always @(negedge clk) begin
    bit ew;
    logic [AW-1:0] ea;
    logic [W-1:0]  ed;
    if (cmp_en) begin
      ew = 0; ea = '0; ed = '0;
      if (rst_n && bus.RegWriteW && bus.RdW != 0) begin
        ew = 1; ea = bus.RdW; ed = bus.ResultW;
      end else if (mq.size() > 0) begin
        ew = 1; ea = mq[0].rd; ed = mq[0].data;
      end
      chk("m_rf_we",     64'(bus.rf_we),     64'(ew));
      chk("m_rf_addr",   64'(bus.rf_addr),   64'(ea));
      chk("m_rf_wd",     64'(bus.rf_wd),     64'(ed));
      chk("m_pend_cnt",  64'(bus.pend_cnt),  64'(mq.size()));
      chk("m_lu_ready",  64'(bus.lu_ready),  64'(mq.size() < DEPTH));
      chk("m_stall_req", 64'(bus.stall_req), 64'(waited >= MAX_WAIT));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.RegWriteW = 0; bus.RdW = '0; bus.ResultW = '0;
    bus.lu_valid = 0; bus.lu_rd = '0; bus.lu_data = '0;
  endtask

  task automatic pipe(input logic [AW-1:0] rd, input logic [W-1:0] d);
    bus.RegWriteW = 1; bus.RdW = rd; bus.ResultW = d;
  endtask

  task automatic lu(input logic [AW-1:0] rd, input logic [W-1:0] d);
    bus.lu_valid = 1; bus.lu_rd = rd; bus.lu_data = d;
  endtask

  initial begin
    idle();
    rst_n = 0;
    step(); step();
    cmp_en = 1;
    #1;
    chk("rst_rf_we", 64'(bus.rf_we), 0);
    chk("rst_pend", 64'(bus.pend_cnt), 0);
    chk("rst_ready", 64'(bus.lu_ready), 1);
    chk("rst_stall", 64'(bus.stall_req), 0);
    rst_n = 1;
    step();

    // Idle-slot drain
    lu(5, 32'hDEAD);
    step();
    idle(); #1;
    chk("drain_we", 64'(bus.rf_we), 1);
    chk("drain_addr", 64'(bus.rf_addr), 5);
    chk("drain_wd", 64'(bus.rf_wd), 32'hDEAD);
    step();
    chk("drain_pend", 64'(bus.pend_cnt), 0);

    // Pipeline priority
    lu(9, 32'h99);
    step();
    idle(); pipe(7, 32'h11); #1;
    chk("prio_addr", 64'(bus.rf_addr), 7);
    chk("prio_wd", 64'(bus.rf_wd), 32'h11);
    chk("prio_pend", 64'(bus.pend_cnt), 1);
    step();
    idle(); #1;
    chk("prio_q_addr", 64'(bus.rf_addr), 9);
    chk("prio_q_wd", 64'(bus.rf_wd), 32'h99);
    step();

    // Starvation bubble
    pipe(3, 32'h33); lu(4, 32'h44);
    step();
    bus.lu_valid = 0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      chk("starve_early", 64'(bus.stall_req), 0);
      step();
    end
    chk("starve_stall", 64'(bus.stall_req), 1);
    step();
    chk("starve_hold", 64'(bus.stall_req), 1);
    chk("starve_pend", 64'(bus.pend_cnt), 1);
    idle(); #1;
    chk("starve_addr", 64'(bus.rf_addr), 4);
    chk("starve_wd", 64'(bus.rf_wd), 32'h44);
    step();
    chk("starve_clear", 64'(bus.stall_req), 0);
    chk("starve_pend0", 64'(bus.pend_cnt), 0);

    // Full and pointer wrap, two waves
    for (int wv = 0; wv < 2; wv++) begin
      pipe(1, 32'h1);
      for (int k = 0; k < DEPTH; k++) begin
        lu(AW'(10 + 6 * wv + k), 32'hA0 + 32'(16 * wv + k));
        step();
      end
      chk("full_ready", 64'(bus.lu_ready), 0);
      chk("full_pend", 64'(bus.pend_cnt), DEPTH);
      lu(20, 32'hBAD);
      step();
      chk("full_ignored", 64'(bus.pend_cnt), DEPTH);
      idle();
      for (int k = 0; k < DEPTH; k++) begin
        #1;
        chk("wrap_addr", 64'(bus.rf_addr), 64'(10 + 6 * wv + k));
        chk("wrap_wd", 64'(bus.rf_wd), 64'(32'hA0 + 16 * wv + k));
        step();
      end
      chk("wrap_pend0", 64'(bus.pend_cnt), 0);
    end

    // x0 handling
    lu(0, 32'h77);
    step();
    idle(); #1;
    chk("x0_pend", 64'(bus.pend_cnt), 0);
    chk("x0_we", 64'(bus.rf_we), 0);
    lu(6, 32'h66);
    step();
    idle(); pipe(0, 32'h55); #1;
    chk("x0_slot_addr", 64'(bus.rf_addr), 6);
    chk("x0_slot_wd", 64'(bus.rf_wd), 32'h66);
    step();
    idle();

    // Reset mid-drain with three queued
    pipe(2, 32'h2);
    for (int k = 0; k < 3; k++) begin
      lu(AW'(21 + k), 32'hC0 + 32'(k));
      step();
    end
    idle(); #1;
    chk("mid_we", 64'(bus.rf_we), 1);
    chk("mid_pend", 64'(bus.pend_cnt), 3);
    rst_n = 0; #1;
    chk("mid_rst_we", 64'(bus.rf_we), 0);
    chk("mid_rst_pend", 64'(bus.pend_cnt), 0);
    chk("mid_rst_ready", 64'(bus.lu_ready), 1);
    step();
    rst_n = 1;
    step();
    chk("post_rst_we", 64'(bus.rf_we), 0);
    chk("post_rst_pend", 64'(bus.pend_cnt), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
